// File: rtl/pc_fetch_controller.sv
// pc_fetch_controller
//   Owns the per-core fetch PC. Each cycle it selects the next PC from the
//   live redirect sources (br > jr > j), a held (pending) redirect, or the
//   sequential PC+4. The PC advances only when the icache hits and decode is
//   not stalling. A redirect that cannot be applied right away is held until
//   the next advance. HALT freezes fetch until reset.
//
// Ports
//   CLK, RST        clock (rising edge), asynchronous active-high reset
//   ihit            icache delivered the instruction at imemaddr this cycle
//   hazard_stall    decode hazard, PC must hold
//   br_redirect/br_target   EX branch redirect (highest priority)
//   jr_redirect/jr_target   JR redirect
//   j_redirect/j_target     ID J/JAL redirect (lowest priority)
//   halt            HALT retired, stop fetching
//   pc              registered fetch PC
//   next_pc         PC loaded at the next edge when pc_incr=1
//   pc_incr         PC updates at the next edge
//   imemREN         icache read enable (low once halted)
//   imemaddr        icache address, always equal to pc
//   flush_if        squash IF/ID: advancing onto a redirect target
//   halted          high in the HALTED state
module pc_fetch_controller #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        hazard_stall,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  input  logic        jr_redirect,
  input  logic [31:0] jr_target,
  input  logic        j_redirect,
  input  logic [31:0] j_target,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        pc_incr,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic        flush_if,
  output logic        halted
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc_d;
  logic [31:0] pend_target, pend_target_d;
  logic        pend_valid, pend_valid_d;
  logic        pend_is_br, pend_is_br_d;

  logic        live_redirect;
  logic [31:0] live_target;
  logic        advance;

  // Live redirect select, targets forced word-aligned.
  always_comb begin
    live_redirect = br_redirect | jr_redirect | j_redirect;
    if (br_redirect) begin
      live_target = {br_target[31:2], 2'b00};
    end else if (jr_redirect) begin
      live_target = {jr_target[31:2], 2'b00};
    end else begin
      live_target = {j_target[31:2], 2'b00};
    end
  end

  // RST gates advance so pc_incr/flush_if stay low while reset is held.
  always_comb begin
    advance  = ihit & ~hazard_stall & (state != HALTED) & ~halt & ~RST;

    if (live_redirect) begin
      next_pc = live_target;
    end else if (pend_valid) begin
      next_pc = pend_target;
    end else begin
      next_pc = pc + 32'd4;
    end

    pc_incr  = advance;
    flush_if = advance & (live_redirect | pend_valid);
    imemREN  = (state != HALTED);
    imemaddr = pc;
    halted   = (state == HALTED);
  end

  // Next-state logic.
  always_comb begin
    state_d       = state;
    pc_d          = pc;
    pend_target_d = pend_target;
    pend_valid_d  = pend_valid;
    pend_is_br_d  = pend_is_br;

    unique case (state)
      RUN: begin
        if (advance) begin
          pc_d = next_pc;
        end else if (live_redirect) begin
          pend_target_d = live_target;
          pend_valid_d  = 1'b1;
          pend_is_br_d  = br_redirect;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (advance) begin
          pc_d         = next_pc;
          pend_valid_d = 1'b0;
          pend_is_br_d = 1'b0;
          state_d      = RUN;
        end else if (br_redirect) begin
          pend_target_d = live_target;
          pend_is_br_d  = 1'b1;
        end else if ((jr_redirect | j_redirect) && !pend_is_br) begin
          // A held branch redirect outranks any later jr/j.
          pend_target_d = live_target;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Halt overrides everything above: pc frozen, pending redirect dropped.
    if (halt && state != HALTED) begin
      state_d       = HALTED;
      pc_d          = pc;
      pend_valid_d  = 1'b0;
      pend_is_br_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= RUN;
      pc          <= PC_RESET;
      pend_target <= '0;
      pend_valid  <= 1'b0;
      pend_is_br  <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      pend_target <= pend_target_d;
      pend_valid  <= pend_valid_d;
      pend_is_br  <= pend_is_br_d;
    end
  end

endmodule
